cam_writer: RTL and testbench

CAM_WRITER -- requirements
Module: cam_writer

---
 rtl/cam_pkg.sv | 45 ++++
 rtl/cam_scan.sv | 90 +++++++++
 rtl/cam_writer.sv | 196 +++++++++++++++++++
 tb/tb_cam_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the CAM write-side controller.
//   - opcode and FSM state enumerations
//   - default table geometry (ENTRIES / DATA_W)
//   - CAM_DUP_CHECK_EN: 1 when the macro CAM_WRITER_DUP_CHECK_EN is defined,
//     enabling duplicate-key rejection on WRITE and INSERT.
package cam_pkg;

  localparam int CAM_ENTRIES_DEF = 4;
  localparam int CAM_DATA_W_DEF  = 4;

`ifdef CAM_WRITER_DUP_CHECK_EN
  localparam bit CAM_DUP_CHECK_EN = 1'b1;
`else
  localparam bit CAM_DUP_CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_INVAL  = 2'b01,
    OP_INSERT = 2'b10,
    OP_CLEAR  = 2'b11
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_COMMIT = 2'b10,
    ST_RESP   = 2'b11
  } cam_state_e;

  // INSERT always needs a free-entry search; WRITE needs a pass over the
  // table only when duplicate keys must be detected.
  function automatic logic op_needs_scan(input cam_op_e op);
    logic res;
    case (op)
      OP_INSERT: res = 1'b1;
      OP_WRITE:  res = CAM_DUP_CHECK_EN;
      OP_INVAL:  res = 1'b0;
      OP_CLEAR:  res = 1'b0;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cam_scan.sv
// cam_scan: sequential table walker used by cam_writer.
// Examines one entry per cycle while en_i is high, walking index
// 0..ENTRIES-1 and wrapping to 0 after the last entry. Accumulates:
//   free_found_o / free_idx_o : lowest-index invalid entry seen
//   dup_found_o               : a valid entry holds key_i (entry excl_addr_i
//                               ignored when excl_en_i); only when the macro
//                               CAM_WRITER_DUP_CHECK_EN is defined
// Ports:
//   clk, reset (async active-low), clr_i (restart flags and index),
//   en_i (scan step), key_i, excl_en_i, excl_addr_i,
//   table_data_i / table_valid_i (current table), last_o (index at last entry)
module cam_scan
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES_DEF,
  parameter int DATA_W  = CAM_DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic [DATA_W-1:0]           key_i,
  input  logic                        excl_en_i,
  input  logic [$clog2(ENTRIES)-1:0]  excl_addr_i,
  input  logic [ENTRIES*DATA_W-1:0]   table_data_i,
  input  logic [ENTRIES-1:0]          table_valid_i,
  output logic                        last_o,
  output logic                        free_found_o,
  output logic [$clog2(ENTRIES)-1:0]  free_idx_o,
  output logic                        dup_found_o
);

  localparam int AW = $clog2(ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  logic [AW-1:0]     idx_q;
  logic              free_found_q;
  logic [AW-1:0]     free_idx_q;
  logic              dup_q;
  logic [DATA_W-1:0] entry_key_s;
  logic              entry_valid_s;
  logic              hit_s;

  // Compare the entry under the scan index against the captured key.
  always_comb begin
    entry_key_s   = table_data_i[idx_q*DATA_W +: DATA_W];
    entry_valid_s = table_valid_i[idx_q];
    if (CAM_DUP_CHECK_EN && entry_valid_s && (entry_key_s == key_i) &&
        !(excl_en_i && (idx_q == excl_addr_i))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Scan index and sticky result flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= {AW{1'b0}};
      free_found_q <= 1'b0;
      free_idx_q   <= {AW{1'b0}};
      dup_q        <= 1'b0;
    end else if (clr_i) begin
      idx_q        <= {AW{1'b0}};
      free_found_q <= 1'b0;
      free_idx_q   <= {AW{1'b0}};
      dup_q        <= 1'b0;
    end else if (en_i) begin
      // First invalid entry wins: later ones must not override it.
      if (!entry_valid_s && !free_found_q) begin
        free_found_q <= 1'b1;
        free_idx_q   <= idx_q;
      end
      if (hit_s) begin
        dup_q <= 1'b1;
      end
      if (idx_q == LAST_IDX) begin
        idx_q <= {AW{1'b0}};
      end else begin
        idx_q <= idx_q + AW'(1'b1);
      end
    end
  end

  assign last_o       = (idx_q == LAST_IDX);
  assign free_found_o = free_found_q;
  assign free_idx_o   = free_idx_q;
  assign dup_found_o  = dup_q;

endmodule

// File: rtl/cam_writer.sv
// cam_writer: write-side controller of a small CAM table.
// Accepts WRITE / INVAL / INSERT / CLEAR commands, optionally scans the
// table (cam_scan), commits the update in a single COMMIT cycle and holds a
// response until it is consumed. Table outputs feed the lookup side.
// Optional feature: define CAM_WRITER_DUP_CHECK_EN to reject duplicate keys;
// without it WRITE goes straight to COMMIT and INSERT scans only for space.
// Ports:
//   clk, reset (async active-low)
//   wr_valid/wr_ready, wr_op, wr_addr, wr_data : command channel
//   resp_valid/resp_ready, resp_err, resp_addr  : response channel
//   table_data (entry i at [i*DATA_W +: DATA_W]), table_valid, busy
module cam_writer
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES_DEF,
  parameter int DATA_W  = CAM_DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [1:0]                  wr_op,
  input  logic [$clog2(ENTRIES)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_err,
  output logic [$clog2(ENTRIES)-1:0]  resp_addr,
  output logic [ENTRIES*DATA_W-1:0]   table_data,
  output logic [ENTRIES-1:0]          table_valid,
  output logic                        busy
);

  localparam int AW = $clog2(ENTRIES);

  cam_state_e                state_q;
  cam_op_e                   op_q;
  logic [AW-1:0]             addr_q;
  logic [DATA_W-1:0]         data_q;
  logic [ENTRIES*DATA_W-1:0] table_data_q;
  logic [ENTRIES-1:0]        table_valid_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [AW-1:0]             resp_addr_q;
  logic                      wr_ready_q;
  logic                      busy_q;

  logic                      accept_s;
  logic                      scan_last_s;
  logic                      free_found_s;
  logic [AW-1:0]             free_idx_s;
  logic                      dup_found_s;
  logic [AW-1:0]             commit_tgt_s;
  logic                      commit_err_d;
  logic [AW-1:0]             commit_addr_d;

  assign accept_s = (state_q == ST_IDLE) && wr_valid;

  cam_scan #(
    .ENTRIES (ENTRIES),
    .DATA_W  (DATA_W)
  ) u_scan (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (accept_s),
    .en_i          (state_q == ST_SCAN),
    .key_i         (data_q),
    .excl_en_i     (op_q == OP_WRITE),
    .excl_addr_i   (addr_q),
    .table_data_i  (table_data_q),
    .table_valid_i (table_valid_q),
    .last_o        (scan_last_s),
    .free_found_o  (free_found_s),
    .free_idx_o    (free_idx_s),
    .dup_found_o   (dup_found_s)
  );

  // Outcome of the captured command once scanning is complete.
  always_comb begin
    commit_err_d = 1'b0;
    commit_tgt_s = {AW{1'b0}};
    case (op_q)
      OP_WRITE: begin
        commit_err_d = dup_found_s;
        commit_tgt_s = addr_q;
      end
      OP_INSERT: begin
        commit_err_d = dup_found_s | ~free_found_s;
        commit_tgt_s = free_idx_s;
      end
      OP_INVAL: begin
        commit_tgt_s = addr_q;
      end
      OP_CLEAR: begin
        commit_tgt_s = {AW{1'b0}};
      end
      default: begin
        commit_err_d = 1'b0;
        commit_tgt_s = {AW{1'b0}};
      end
    endcase
    if (commit_err_d) begin
      commit_addr_d = {AW{1'b0}};
    end else begin
      commit_addr_d = commit_tgt_s;
    end
  end

  // Command FSM, table registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= {AW{1'b0}};
      data_q        <= {DATA_W{1'b0}};
      table_data_q  <= {(ENTRIES*DATA_W){1'b0}};
      table_valid_q <= {ENTRIES{1'b0}};
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_addr_q   <= {AW{1'b0}};
      wr_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_valid) begin
            op_q       <= cam_op_e'(wr_op);
            addr_q     <= wr_addr;
            data_q     <= wr_data;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (op_needs_scan(cam_op_e'(wr_op))) begin
              state_q <= ST_SCAN;
            end else begin
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_SCAN: begin
          if (scan_last_s) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // The table is only ever modified here, and never on error.
          if (!commit_err_d) begin
            case (op_q)
              OP_WRITE, OP_INSERT: begin
                table_data_q[commit_tgt_s*DATA_W +: DATA_W] <= data_q;
                table_valid_q[commit_tgt_s]                 <= 1'b1;
              end
              OP_INVAL: begin
                table_valid_q[addr_q] <= 1'b0;
              end
              OP_CLEAR: begin
                table_valid_q <= {ENTRIES{1'b0}};
              end
              default: begin
                table_valid_q <= table_valid_q;
              end
            endcase
          end
          resp_err_q  <= commit_err_d;
          resp_addr_q <= commit_addr_d;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // resp_valid rises one cycle after entering RESP.
          if (resp_valid_q && resp_ready) begin
            resp_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            resp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          wr_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready    = wr_ready_q;
  assign busy        = busy_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_addr   = resp_addr_q;
  assign table_data  = table_data_q;
  assign table_valid = table_valid_q;

endmodule

// File: tb/tb_cam_writer.sv
// tb_cam_writer: scoreboard bench for cam_writer (ENTRIES=4, DATA_W=4).
// The driver issues commands, evaluates them on an array-based table model
// and queues the expected response; an independent monitor checks each
// response (latency, err, addr, table contents) and channel stability.
// Honours CAM_WRITER_DUP_CHECK_EN the same way the design does.
module tb_cam_writer;

  localparam int ENTRIES = 4;
  localparam int DATA_W  = 4;
  localparam logic [1:0] C_WRITE  = 2'b00;
  localparam logic [1:0] C_INVAL  = 2'b01;
  localparam logic [1:0] C_INSERT = 2'b10;
  localparam logic [1:0] C_CLEAR  = 2'b11;
`ifdef CAM_WRITER_DUP_CHECK_EN
  localparam bit TB_DUP = 1'b1;
`else
  localparam bit TB_DUP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_op;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [1:0]  resp_addr;
  logic [15:0] table_data;
  logic [3:0]  table_valid;
  logic        busy;

  cam_writer #(.ENTRIES(ENTRIES), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_op       (wr_op),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_err    (resp_err),
    .resp_addr   (resp_addr),
    .table_data  (table_data),
    .table_valid (table_valid),
    .busy        (busy)
  );

  typedef struct {
    logic        err;
    logic [1:0]  addr;
    logic [3:0]  tv;
    logic [15:0] td;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mk[ENTRIES];
  bit         mv[ENTRIES];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;
  bit         hold_req = 0;
  int         held = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < ENTRIES; j++) begin
      mk[j] = 4'h0;
      mv[j] = 1'b0;
    end
  endtask

  // Reference behaviour: search the whole table at once, then apply.
  task automatic model_cmd(input logic [1:0] op, input logic [1:0] addr,
                           input logic [3:0] data, output exp_t e);
    bit dup;
    int free;
    bit err;
    dup  = 1'b0;
    free = -1;
    for (int j = 0; j < ENTRIES; j++) begin
      if (mv[j] && mk[j] == data && (op == C_INSERT || j != int'(addr))) dup = 1'b1;
    end
    for (int j = ENTRIES - 1; j >= 0; j--) begin
      if (!mv[j]) free = j;
    end
    if (!TB_DUP || op == C_INVAL || op == C_CLEAR) dup = 1'b0;
    err = dup || (op == C_INSERT && free < 0);
    e.err  = err;
    e.addr = 2'd0;
    if (!err) begin
      case (op)
        C_WRITE:  begin mk[addr] = data; mv[addr] = 1'b1; e.addr = addr; end
        C_INSERT: begin mk[free] = data; mv[free] = 1'b1; e.addr = 2'(free); end
        C_INVAL:  begin mv[addr] = 1'b0; e.addr = addr; end
        default:  begin for (int j = 0; j < ENTRIES; j++) mv[j] = 1'b0; end
      endcase
    end
    for (int j = 0; j < ENTRIES; j++) begin
      e.tv[j] = mv[j];
      e.td[j*4 +: 4] = mk[j];
    end
    if (op == C_INSERT || (op == C_WRITE && TB_DUP)) e.lat = ENTRIES + 2;
    else e.lat = 2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] addr,
                       input logic [3:0] data, input bit push);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!wr_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_ready_timeout: got 0 expected 1 (cycle %0d)", cycle);
    end
    wr_valid = 1'b1;
    wr_op    = op;
    wr_addr  = addr;
    wr_data  = data;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    if (push) begin
      model_cmd(op, addr, data, e);
      e.acc = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Response-side backpressure: random, or a fixed 5-cycle stall.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_req) begin
        if (resp_valid) begin
          if (held < 5) begin
            resp_ready = 1'b0;
            held++;
          end else begin
            resp_ready = 1'b1;
            hold_req = 1'b0;
            held = 0;
          end
        end else begin
          resp_ready = 1'b0;
        end
      end else begin
        resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops and checks whenever the DUT presents a response.
  initial begin
    bit         pend;
    bit         expect_low;
    logic       perr;
    logic [1:0] paddr;
    exp_t       e;
    pend = 1'b0;
    expect_low = 1'b0;
    perr = 1'b0;
    paddr = 2'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
        expect_low = 1'b0;
      end else begin
        if (expect_low) begin
          chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
          chk("wr_ready_after_hs", 32'(wr_ready), 32'd1);
          expect_low = 1'b0;
        end
        if (resp_valid) begin
          chk("wr_ready_in_resp", 32'(wr_ready), 32'd0);
          chk("busy_in_resp", 32'(busy), 32'd1);
          if (!pend) begin
            pend = 1'b1;
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL resp_unexpected: got resp_valid=1 expected no response");
            end else begin
              chk("latency", 32'(cycle - sb[0].acc), 32'(sb[0].lat));
            end
          end else begin
            chk("resp_err_stable", 32'(resp_err), 32'(perr));
            chk("resp_addr_stable", 32'(resp_addr), 32'(paddr));
          end
          perr = resp_err;
          paddr = resp_addr;
          if (resp_ready) begin
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("resp_err", 32'(resp_err), 32'(e.err));
              chk("resp_addr", 32'(resp_addr), 32'(e.addr));
              chk("table_valid", 32'(table_valid), 32'(e.tv));
              chk("table_data", 32'(table_data), 32'(e.td));
            end
            pend = 1'b0;
            expect_low = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_op    = 2'b00;
    wr_addr  = 2'd0;
    wr_data  = 4'h0;
    model_clear();
    #12;
    chk("rst_table_valid", 32'(table_valid), 32'd0);
    chk("rst_table_data", 32'(table_data), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_addr", 32'(resp_addr), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed: write, inserts, full table, duplicates.
    issue(C_WRITE, 2'd2, 4'hE, 1'b1);
    issue(C_INSERT, 2'd0, 4'hB, 1'b1);
    issue(C_INSERT, 2'd0, 4'h1, 1'b1);
    issue(C_INSERT, 2'd0, 4'h7, 1'b1);
    issue(C_INSERT, 2'd0, 4'h5, 1'b1);
    issue(C_WRITE, 2'd3, 4'hB, 1'b1);
    issue(C_WRITE, 2'd0, 4'hB, 1'b1);
    issue(C_INVAL, 2'd1, 4'h0, 1'b1);
    issue(C_INSERT, 2'd0, 4'h1, 1'b1);
    drain();

    // Held-off response consumer.
    hold_req = 1'b1;
    issue(C_INVAL, 2'd3, 4'h0, 1'b1);
    drain();
    hold_req = 1'b1;
    issue(C_INSERT, 2'd0, 4'h9, 1'b1);
    drain();

    // Randomized commands over a small key space to provoke duplicates.
    for (int n = 0; n < 60; n++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 7)), 1'b1);
    end
    drain();

    // Reset in the middle of a WRITE, then CLEAR.
    issue(C_WRITE, 2'd1, 4'h3, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_table_valid", 32'(table_valid), 32'd0);
    chk("midrst_table_data", 32'(table_data), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    sb.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("postrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
    issue(C_CLEAR, 2'd0, 4'h0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("final_resp_valid", 32'(resp_valid), 32'd0);
    chk("final_wr_ready", 32'(wr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
